// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the program-counter sequencer.
//   state_e  - sequencer FSM states (FETCH, EXEC, FAULT)
//   FC_*     - fault_code encodings reported on the fault_code output
package pc_seq_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_OVF     = 2'b01;  // call with return stack full
  localparam logic [1:0] FC_UNF     = 2'b10;  // ret with return stack empty
  localparam logic [1:0] FC_CALLRET = 2'b11;  // call and ret in one instruction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: decoder/fetch/status bundle for pc_sequencer.
//   decoder side : step, has_immediate, jump_immediate, jump_stack, branch,
//                  call, ret, immediate, top, branch_offset
//   fetch side   : fetch_valid, fetch_ready, fetch_addr
//   status       : pc, call_depth, fault, fault_code
//   trace (only with PC_SEQ_TRACE_EN): trace_valid, trace_from, trace_to
// master = the sequencer, slave = the surrounding core/memory.
interface pc_sequencer_if #(
  parameter int WORD_WIDTH         = 32,
  parameter int PROGRAM_ADDR_WIDTH = 32,
  parameter int BRANCH_WIDTH       = 16,
  parameter int CALL_DEPTH         = 16
);
  localparam int DW = $clog2(CALL_DEPTH + 1);

  logic                          step;
  logic                          has_immediate;
  logic                          jump_immediate;
  logic                          jump_stack;
  logic                          branch;
  logic                          call;
  logic                          ret;
  logic [PROGRAM_ADDR_WIDTH-1:0] immediate;
  logic [WORD_WIDTH-1:0]         top;
  logic [BRANCH_WIDTH-1:0]       branch_offset;
  logic                          fetch_ready;
  logic                          fetch_valid;
  logic [PROGRAM_ADDR_WIDTH-1:0] fetch_addr;
  logic [PROGRAM_ADDR_WIDTH-1:0] pc;
  logic [DW-1:0]                 call_depth;
  logic                          fault;
  logic [1:0]                    fault_code;
`ifdef PC_SEQ_TRACE_EN
  logic                          trace_valid;
  logic [PROGRAM_ADDR_WIDTH-1:0] trace_from;
  logic [PROGRAM_ADDR_WIDTH-1:0] trace_to;
`endif

  modport master (
    input  step, has_immediate, jump_immediate, jump_stack, branch, call, ret,
    input  immediate, top, branch_offset, fetch_ready,
`ifdef PC_SEQ_TRACE_EN
    output trace_valid, trace_from, trace_to,
`endif
    output fetch_valid, fetch_addr, pc, call_depth, fault, fault_code
  );

  modport slave (
    output step, has_immediate, jump_immediate, jump_stack, branch, call, ret,
    output immediate, top, branch_offset, fetch_ready,
`ifdef PC_SEQ_TRACE_EN
    input  trace_valid, trace_from, trace_to,
`endif
    input  fetch_valid, fetch_addr, pc, call_depth, fault, fault_code
  );

endinterface

// File: rtl/return_stack.sv
// return_stack: small LIFO holding call return addresses.
//   clk, reset   - clock, synchronous active-high reset (empties the stack)
//   push, din    - write din on top (ignored when full)
//   pop          - drop top entry (ignored when empty)
//   dout         - current top entry (undefined when empty)
//   full, empty  - occupancy flags
//   depth        - number of occupied entries
module return_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DW-1:0]    sp_q;
  logic [DW-1:0]    sp_m1;

  assign full  = (sp_q == DW'(DEPTH));
  assign empty = (sp_q == '0);
  assign depth = sp_q;
  assign sp_m1 = sp_q - DW'(1);
  // DEPTH is a power of two, so the low AW bits index the array directly.
  assign dout  = mem_q[sp_m1[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset)               sp_q <= '0;
    else if (push && !full)  sp_q <= sp_q + DW'(1);
    else if (pop && !empty)  sp_q <= sp_m1;
  end

  // Entries are not cleared on reset; sp_q == 0 makes them unreachable.
  always_ff @(posedge clk) begin
    if (!reset && push && !full) mem_q[sp_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, fetch handshake and return-address stack.
//   clk, reset - clock, synchronous active-high reset
//   bus        - pc_sequencer_if.master (decoder decisions in, fetch request
//                and status out)
// FSM: FETCH (request pc) -> EXEC (wait for step) -> FETCH, or -> FAULT on a
// return-stack error; FAULT is left only through reset.
// Optional macro PC_SEQ_TRACE_EN adds trace_valid/trace_from/trace_to, which
// report every retired step whose next pc is not the sequential address.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                            WORD_WIDTH         = 32,
  parameter int                            PROGRAM_ADDR_WIDTH = 32,
  parameter int                            BRANCH_WIDTH       = 16,
  parameter int                            CALL_DEPTH         = 16,
  parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_VECTOR       = '0
) (
  input logic            clk,
  input logic            reset,
  pc_sequencer_if.master bus
);
  localparam int PAW = PROGRAM_ADDR_WIDTH;
  localparam int DW  = $clog2(CALL_DEPTH + 1);

  state_e         state_q, state_d;
  logic [PAW-1:0] pc_q, pc_d;
  logic           fault_q, fault_d;
  logic [1:0]     code_q, code_d;
  logic           fv;

  logic           push, pop, rs_full, rs_empty;
  logic [PAW-1:0] rs_top;
  logic [DW-1:0]  rs_depth;
  logic [PAW-1:0] seq, br_tgt, tgt;

  // Only the low PAW bits of top address memory.
  logic unused_top;
  assign unused_top = &{1'b0, bus.top};

  assign seq    = pc_q + PAW'(1) + PAW'(bus.has_immediate);
  assign br_tgt = pc_q + PAW'($signed(bus.branch_offset));

  // ret pops even when a jump/branch wins the target selection.
  always_comb begin
    tgt = seq;
    if (bus.jump_stack)          tgt = bus.top[PAW-1:0];
    else if (bus.jump_immediate) tgt = bus.immediate;
    else if (bus.branch)         tgt = br_tgt;
    else if (bus.ret)            tgt = rs_top;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    code_d  = code_q;
    push    = 1'b0;
    pop     = 1'b0;
    fv      = 1'b0;
    case (state_q)
      FETCH: begin
        fv = !reset;
        if (fv && bus.fetch_ready) state_d = EXEC;
      end
      EXEC: begin
        if (bus.step) begin
          // Faults leave pc and the stack untouched.
          if (bus.call && bus.ret) begin
            fault_d = 1'b1; code_d = FC_CALLRET; state_d = FAULT;
          end else if (bus.call && rs_full) begin
            fault_d = 1'b1; code_d = FC_OVF;     state_d = FAULT;
          end else if (bus.ret && rs_empty) begin
            fault_d = 1'b1; code_d = FC_UNF;     state_d = FAULT;
          end else begin
            pc_d    = tgt;
            push    = bus.call;
            pop     = bus.ret;
            state_d = FETCH;
          end
        end
      end
      default: ;  // FAULT: frozen until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  return_stack #(
    .WIDTH (PAW),
    .DEPTH (CALL_DEPTH)
  ) u_rs (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (seq),
    .dout  (rs_top),
    .full  (rs_full),
    .empty (rs_empty),
    .depth (rs_depth)
  );

  assign bus.fetch_valid = fv;
  assign bus.fetch_addr  = pc_q;
  assign bus.pc          = pc_q;
  assign bus.call_depth  = rs_depth;
  assign bus.fault       = fault_q;
  assign bus.fault_code  = code_q;

`ifdef PC_SEQ_TRACE_EN
  logic           trv_q;
  logic [PAW-1:0] trf_q, trt_q;
  logic           retire;

  assign retire = (state_q == EXEC) && bus.step && (state_d == FETCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      trv_q <= 1'b0;
      trf_q <= '0;
      trt_q <= '0;
    end else begin
      trv_q <= retire && (pc_d != seq);
      if (retire && (pc_d != seq)) begin
        trf_q <= pc_q;
        trt_q <= pc_d;
      end
    end
  end

  assign bus.trace_valid = trv_q;
  assign bus.trace_from  = trf_q;
  assign bus.trace_to    = trt_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WORD_WIDTH(32), .PROGRAM_ADDR_WIDTH(32), .BRANCH_WIDTH(16), .CALL_DEPTH(16)) bus ();

  pc_sequencer #(
    .WORD_WIDTH(32), .PROGRAM_ADDR_WIDTH(32), .BRANCH_WIDTH(16),
    .CALL_DEPTH(16), .RESET_VECTOR(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        hi, ji, js, br, ca, re;
    logic [31:0] imm, top;
    logic [15:0] off;
    logic [31:0] ea;
    logic [4:0]  ed;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [4:0]  depth;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[17];

  function automatic vec_t mk(logic hi, ji, js, br, ca, re,
                              logic [31:0] imm, logic [31:0] top, logic [15:0] off,
                              logic [31:0] ea, logic [4:0] ed);
    vec_t v;
    v.hi = hi; v.ji = ji; v.js = js; v.br = br; v.ca = ca; v.re = re;
    v.imm = imm; v.top = top; v.off = off; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    bus.step = 1'b1;
    bus.has_immediate = v.hi; bus.jump_immediate = v.ji; bus.jump_stack = v.js;
    bus.branch = v.br; bus.call = v.ca; bus.ret = v.re;
    bus.immediate = v.imm; bus.top = v.top; bus.branch_offset = v.off;
  endtask

  task automatic idle();
    bus.step = 1'b0; bus.has_immediate = 1'b0; bus.jump_immediate = 1'b0;
    bus.jump_stack = 1'b0; bus.branch = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.immediate = '0; bus.top = '0; bus.branch_offset = '0;
  endtask

  // Waits (bounded) for a fetch request and compares it with the scoreboard head.
  task automatic check_fetch(string tag);
    int   waited = -1;
    exp_t e;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fetch_valid === 1'b1) begin waited = i; break; end
    end
    chk({tag, "_latency"}, 64'(waited), 64'd0);
    if (waited >= 0) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_addr"}, 64'(bus.fetch_addr), 64'(e.addr));
        chk({tag, "_depth"}, 64'(bus.call_depth), 64'(e.depth));
        chk({tag, "_fault"}, 64'(bus.fault), 64'd0);
      end
    end
  endtask

  task automatic run_vec(vec_t v, string tag);
    @(posedge clk); #1;
    drive(v);
    sb.push_back('{v.ea, v.ed});
    @(posedge clk); #1;
    idle();
    check_fetch(tag);
  endtask

  task automatic fault_step(vec_t v, logic [1:0] code, logic [31:0] pc_exp,
                            logic [4:0] d_exp, string tag);
    @(posedge clk); #1;
    drive(v);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    chk({tag, "_fault"}, 64'(bus.fault), 64'd1);
    chk({tag, "_code"}, 64'(bus.fault_code), 64'(code));
    chk({tag, "_fv"}, 64'(bus.fetch_valid), 64'd0);
    chk({tag, "_pc"}, 64'(bus.pc), 64'(pc_exp));
    chk({tag, "_depth"}, 64'(bus.call_depth), 64'(d_exp));
  endtask

  task automatic do_reset(string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk({tag, "_fv_in_reset"}, 64'(bus.fetch_valid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.fetch_ready = 1'b1;
    sb.delete();
    sb.push_back('{32'h0, 5'd0});
    check_fetch(tag);
    chk({tag, "_code"}, 64'(bus.fault_code), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //            hi ji js br ca re  imm            top            off       exp addr       depth
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         16'h0,    32'h1,         5'd0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,         16'h0,    32'h3,         5'd0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 32'h10,       32'h0,         16'h0,    32'h10,        5'd0);
    tbl[3]  = mk(0, 0, 0, 1, 0, 0, 32'h0,        32'h0,         16'hFFFC, 32'h0C,        5'd0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,         16'h0,    32'h0,         5'd0);
    tbl[5]  = mk(0, 0, 0, 1, 0, 0, 32'h0,        32'h0,         16'hFFFF, 32'hFFFFFFFF,  5'd0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,         16'h0,    32'h0,         5'd0);
    tbl[7]  = mk(0, 1, 0, 0, 0, 0, 32'h20,       32'h0,         16'h0,    32'h20,        5'd0);
    tbl[8]  = mk(1, 1, 0, 0, 1, 0, 32'h100,      32'h0,         16'h0,    32'h100,       5'd1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         16'h0,    32'h22,        5'd0);
    tbl[10] = mk(0, 0, 1, 0, 0, 0, 32'h0,        32'hDEAD0040,  16'h0,    32'hDEAD0040,  5'd0);
    tbl[11] = mk(0, 0, 0, 0, 1, 0, 32'h0,        32'h0,         16'h0,    32'hDEAD0041,  5'd1);
    tbl[12] = mk(0, 1, 0, 0, 0, 1, 32'h500,      32'h0,         16'h0,    32'h500,       5'd0);
    tbl[13] = mk(0, 1, 1, 1, 0, 0, 32'h77,       32'h44,        16'h4,    32'h44,        5'd0);
    tbl[14] = mk(0, 1, 0, 1, 0, 0, 32'h80,       32'h0,         16'h8,    32'h80,        5'd0);
    tbl[15] = mk(1, 0, 0, 1, 1, 0, 32'h0,        32'h0,         16'h10,   32'h90,        5'd1);
    tbl[16] = mk(0, 0, 0, 0, 0, 1, 32'h0,        32'h0,         16'h0,    32'h82,        5'd0);

    idle();
    bus.fetch_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_fv", 64'(bus.fetch_valid), 64'd0);
    chk("reset_pc", 64'(bus.pc), 64'd0);
    chk("reset_depth", 64'(bus.call_depth), 64'd0);
    chk("reset_fault", 64'(bus.fault), 64'd0);
    chk("reset_code", 64'(bus.fault_code), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    sb.push_back('{32'h0, 5'd0});
    check_fetch("first");

    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Stall: fetch held off, step pulses in FETCH must be ignored.
    bus.fetch_ready = 1'b0;
    v = mk(0, 1, 0, 0, 0, 0, 32'h999, 32'h0, 16'h0, 32'h0, 5'd0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      chk($sformatf("stall%0d_fv", i), 64'(bus.fetch_valid), 64'd1);
      chk($sformatf("stall%0d_addr", i), 64'(bus.fetch_addr), 64'h82);
    end
    idle();
    bus.fetch_ready = 1'b1;
    run_vec(mk(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 16'h0, 32'h83, 5'd0), "post_stall");

    // Reset while a fetch is pending.
    bus.fetch_ready = 1'b0;
    do_reset("rst_midfetch");

    // 16 nested calls fill the stack; the 17th overflows.
    for (int i = 0; i < 16; i++)
      run_vec(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 16'h0, 32'(i + 1), 5'(i + 1)),
              $sformatf("call%0d", i));
    fault_step(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0), 2'b01, 32'h10, 5'd16, "ovf");
    v = mk(0, 1, 0, 0, 0, 0, 32'h300, 32'h0, 16'h0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      chk($sformatf("frozen%0d_fv", i), 64'(bus.fetch_valid), 64'd0);
      chk($sformatf("frozen%0d_pc", i), 64'(bus.pc), 64'h10);
    end
    idle();
    do_reset("rst_ovf");
    chk("rst_ovf_fault", 64'(bus.fault), 64'd0);

    // ret on an empty stack.
    fault_step(mk(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 16'h0, 32'h0, 5'd0), 2'b10, 32'h0, 5'd0, "unf");
    do_reset("rst_unf");

    // call and ret together, stack non-empty so only the combination faults.
    run_vec(mk(0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 16'h0, 32'h1, 5'd1), "pre_cr");
    fault_step(mk(0, 1, 0, 0, 1, 1, 32'h40, 32'h0, 16'h0, 32'h0, 5'd0), 2'b11, 32'h1, 5'd1, "callret");
    do_reset("rst_cr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
